// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared alu control codes, default widths and execute-stage occupancy states
package alu_pkg;
  localparam int ALU_OP_W  = 3;
  localparam int ALU_WIDTH = 32;
  localparam int ALU_TAG_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOR = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Result bundle is packed MSB-first as {tag, cout, res}.
  function automatic int result_w(input int width, input int tag_w);
    return tag_w + 1 + width;
  endfunction
endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational alu; cout is carry for ADD, no-borrow (a >= b) for SUB, 0 otherwise
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] ctrl,
  output logic [WIDTH-1:0]    dout,
  output logic                cout
);
  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    diff;
  logic [SH_W-1:0]   shamt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt = b[SH_W-1:0];

  always_comb begin
    dout = '0;
    cout = 1'b0;
    case (ctrl)
      ALU_OP_ADD: begin dout = sum[WIDTH-1:0];  cout = sum[WIDTH];  end
      ALU_OP_SUB: begin dout = diff[WIDTH-1:0]; cout = diff[WIDTH]; end
      ALU_OP_AND: dout = a & b;
      ALU_OP_OR:  dout = a | b;
      ALU_OP_XOR: dout = a ^ b;
      ALU_OP_NOR: dout = ~(a | b);
      ALU_OP_SLL: dout = a << shamt;
      ALU_OP_SRL: dout = a >> shamt;
      default:    dout = '0;
    endcase
  end
endmodule

// File: rtl/exec_skid_buf.sv
// rtl/exec_skid_buf.sv - 2-entry register slice (main + skid), fully registered handshakes
module exec_skid_buf
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         busy_o
);
  occ_e         state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         in_ready_q, out_valid_q;
  logic         accept, drain;

  assign accept = in_valid_i & in_ready_q;
  assign drain  = out_valid_q & out_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: if (accept) state_d = OCC_ONE;
      OCC_ONE: begin
        if (accept && !drain)      state_d = OCC_TWO;
        else if (!accept && drain) state_d = OCC_EMPTY;
      end
      OCC_TWO:   if (drain) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
  end

  // Handshake outputs are registered from next state so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OCC_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != OCC_TWO);
      out_valid_q <= (state_d != OCC_EMPTY);
      case (state_q)
        OCC_EMPTY: if (accept) main_q <= in_data_i;
        OCC_ONE: begin
          if (accept && drain) main_q <= in_data_i;
          else if (accept)     skid_q <= in_data_i;
        end
        OCC_TWO:   if (drain) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  // Occupied exactly when main holds a result.
  assign busy_o      = out_valid_q;
endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered execute stage around alu; ALU_EXEC_FLAGS_EN adds out_zero/out_neg
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = ALU_TAG_W,
  parameter int OP_W  = ALU_OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag,
`ifdef ALU_EXEC_FLAGS_EN
  output logic             out_zero,
  output logic             out_neg,
`endif
  output logic             busy
);
`ifdef ALU_EXEC_FLAGS_EN
  localparam int FLAG_W = 2;
`else
  localparam int FLAG_W = 0;
`endif
  localparam int PAY_W = result_w(WIDTH, TAG_W) + FLAG_W;

  logic [WIDTH-1:0] alu_dout;
  logic             alu_cout;
  logic [PAY_W-1:0] pay_in, pay_out;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a    (in_a),
    .b    (in_b),
    .ctrl (in_op),
    .dout (alu_dout),
    .cout (alu_cout)
  );

`ifdef ALU_EXEC_FLAGS_EN
  assign pay_in = {(alu_dout == '0), alu_dout[WIDTH-1], in_tag, alu_cout, alu_dout};
  assign {out_zero, out_neg, out_tag, out_cout, out_res} = pay_out;
`else
  assign pay_in = {in_tag, alu_cout, alu_dout};
  assign {out_tag, out_cout, out_res} = pay_out;
`endif

  exec_skid_buf #(.W(PAY_W)) u_slice (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (pay_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (pay_out),
    .busy_o      (busy)
  );
endmodule
